regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single register-file write port between the pipeline write-back stage (fed by the MEM/WB pipeline register) and a host/debug write requester. WB writes always win and are never delayed. Host writes are buffered in a small FIFO and drained into idle WB slots. A starvation counter requests a pipeline stall when host writes have waited too long, and pending host writes are squashed when WB overwrites the same register.

## Interface
- PROC_DATA_WIDTH, 16, register data width
- PROC_REGFILE_LOG2_DEEP, 5, register address width
- HOST_FIFO_DEPTH, 2, host write buffer entries (power of two, >= 2)
- STARVE_LIMIT, 8, consecutive blocked cycles before stall_o asserts (>= 1)

- clk_i  input  1  clock, all state updates on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- wb_en_i  input  1  WB-stage write enable
- wb_addr_i  input  PROC_REGFILE_LOG2_DEEP  WB write address
- wb_data_i  input  PROC_DATA_WIDTH  WB write data
- host_valid_i  input  1  host write request
- host_ready_o  output  1  host request accepted this cycle when high with valid
- host_addr_i  input  PROC_REGFILE_LOG2_DEEP  host write address
- host_data_i  input  PROC_DATA_WIDTH  host write data
- rf_we_o  output  1  register-file write enable
- rf_waddr_o  output  PROC_REGFILE_LOG2_DEEP  register-file write address
- rf_wdata_o  output  PROC_DATA_WIDTH  register-file write data
- stall_o  output  1  registered request to freeze upstream pipeline and inject a WB bubble

## Operation
- FIFO entries: {valid, addr, data}, with head/tail pointers and occupancy count. Squashed entries (valid=0) still occupy a slot until popped.
- Host accept: host_valid_i && host_ready_o pushes at tail with valid=1. host_ready_o = (count != HOST_FIFO_DEPTH), combinational from registered count.
- Port mux (combinational):
  - wb_en_i=1: rf_* = WB inputs.
  - else if head is valid: rf_* = head entry, and the head pops.
  - else rf_we_o=0. rf_waddr_o and rf_wdata_o are then 0.
- Invalid head pops every cycle it is at head, independent of wb_en_i, and never drives the port.
- Simultaneous push and pop: count unchanged. A push into a full FIFO is impossible because ready=0; a pop in the same cycle does not raise ready.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - Increments while the head is valid and wb_en_i=1.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_o <= (counter == STARVE_LIMIT) && head valid && !pop. Upstream guarantees wb_en_i=0 within bounded cycles after stall_o; the head then drains and stall_o drops the next cycle.
- While rst_n_i is low, rf_we_o is forced to 0.

## Timing
- Reset values (async): FIFO empty, all valid=0, pointers 0, counter 0, stall_o=0, host_ready_o=1, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
- WB path latency: 0 cycles (combinational pass-through).
- Host write latency: minimum 1 cycle. An entry pushed at edge N can drive the port in cycle N+1 if wb_en_i=0.
- stall_o rises at the edge after the counter reaches STARVE_LIMIT with the head still blocked. It falls at the edge after the head pops.
- Reset mid-operation: all buffered host writes are lost, and no partial write reaches the port.

## Configuration
- REGFILE_ARB_SQUASH_EN defined:
  - When wb_en_i=1, every FIFO entry already stored with valid=1 and addr==wb_addr_i is cleared to valid=0 at that edge.
  - An entry pushed in the same cycle is younger and is not squashed.
  - Outcome: WB writes never get overwritten by older host writes.
- Undefined:
  - No squash logic; all entries drain in order.
  - Ordering between host and WB writes to the same register is the software's responsibility.

## Test plan
- Reset, then idle: rf_we_o=0, host_ready_o=1, stall_o=0. Assert rst_n_i low mid-drain with 2 entries: outputs go 0 immediately, FIFO empties.
- Host push addr=3 data=0x1234, wb_en_i=0: next cycle rf_we_o=1, rf_waddr_o=3, rf_wdata_o=0x1234, FIFO empty after.
- Host push 2 entries while wb_en_i=1 continuously: third request sees host_ready_o=0. WB data passes through every cycle unchanged.
- Hold wb_en_i=1 with head valid, STARVE_LIMIT=8: stall_o rises after 8 blocked cycles. Drop wb_en_i: head writes, and stall_o falls one cycle later.
- With REGFILE_ARB_SQUASH_EN: queue host addr=5 data=0xAAAA, then WB write addr=5 data=0xBBBB. The host entry pops without writing, and the final register 5 value is 0xBBBB. Without the macro, the port later writes 0xAAAA.
- Same-cycle host push addr=7 and WB write addr=7: the WB write goes out first, and the host entry is kept and written afterwards in both configurations.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single register-file write port between the pipeline write-back
// stage and a host/debug write requester. WB writes always own the port and
// are passed straight through. Host writes are buffered in a small FIFO and
// drained into cycles where the WB stage is not writing. When a valid host
// write has been blocked for STARVE_LIMIT consecutive cycles, a registered
// stall request asks the pipeline to inject a WB bubble.
//
// Optional feature: define REGFILE_ARB_SQUASH_EN to squash buffered host
// writes whose address is overwritten by a WB write. A squashed entry keeps
// its FIFO slot and pops without driving the port.
//
// Ports:
//   clk_i          clock, all state updates on rising edge
//   rst_n_i        asynchronous active-low reset
//   wb_en_i        WB-stage write enable
//   wb_addr_i      WB write address
//   wb_data_i      WB write data
//   host_valid_i   host write request
//   host_ready_o   host request accepted this cycle when high with valid
//   host_addr_i    host write address
//   host_data_i    host write data
//   rf_we_o        register-file write enable
//   rf_waddr_o     register-file write address
//   rf_wdata_o     register-file write data
//   stall_o        registered request to freeze upstream and inject a bubble

module regfile_write_arbiter #(
  parameter int PROC_DATA_WIDTH        = 16,
  parameter int PROC_REGFILE_LOG2_DEEP = 5,
  parameter int HOST_FIFO_DEPTH        = 2,
  parameter int STARVE_LIMIT           = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              wb_en_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] wb_addr_i,
  input  logic [PROC_DATA_WIDTH-1:0]        wb_data_i,
  input  logic                              host_valid_i,
  output logic                              host_ready_o,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] host_addr_i,
  input  logic [PROC_DATA_WIDTH-1:0]        host_data_i,
  output logic                              rf_we_o,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] rf_waddr_o,
  output logic [PROC_DATA_WIDTH-1:0]        rf_wdata_o,
  output logic                              stall_o
);

  localparam int PTR_W = $clog2(HOST_FIFO_DEPTH);
  localparam int CNT_W = $clog2(HOST_FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(HOST_FIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  logic                              ent_valid [HOST_FIFO_DEPTH];
  logic [PROC_REGFILE_LOG2_DEEP-1:0] ent_addr  [HOST_FIFO_DEPTH];
  logic [PROC_DATA_WIDTH-1:0]        ent_data  [HOST_FIFO_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;

  logic not_empty;
  logic head_valid;
  logic pop;
  logic push;
  logic blocked;

  // The head pops whenever it can use the port (no WB write) or when it was
  // squashed, in which case it just frees its slot without writing.
  always_comb begin
    not_empty    = (count != '0);
    head_valid   = not_empty && ent_valid[head];
    pop          = not_empty && (!ent_valid[head] || !wb_en_i);
    blocked      = head_valid && wb_en_i;
    host_ready_o = (count != FULL_COUNT);
    push         = host_valid_i && host_ready_o;
  end

  // Port mux: WB has absolute priority; the port is forced idle in reset so
  // no partial write can escape while the FIFO is being cleared.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (rst_n_i) begin
      if (wb_en_i) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = wb_addr_i;
        rf_wdata_o = wb_data_i;
      end else if (head_valid) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = ent_addr[head];
        rf_wdata_o = ent_data[head];
      end
    end
  end

  // FIFO storage. Slots are marked invalid as they pop so only occupied
  // slots can ever hold valid=1. The push is applied after the squash so an
  // entry arriving in the same cycle as a matching WB write survives.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < HOST_FIFO_DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_addr[i]  <= '0;
        ent_data[i]  <= '0;
      end
    end else begin
`ifdef REGFILE_ARB_SQUASH_EN
      for (int i = 0; i < HOST_FIFO_DEPTH; i++) begin
        if (wb_en_i && ent_valid[i] && (ent_addr[i] == wb_addr_i)) begin
          ent_valid[i] <= 1'b0;
        end
      end
`endif
      if (pop) begin
        ent_valid[head] <= 1'b0;
      end
      if (push) begin
        ent_valid[tail] <= 1'b1;
        ent_addr[tail]  <= host_addr_i;
        ent_data[tail]  <= host_data_i;
      end
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Starvation tracking: counts consecutive cycles the valid head is locked
  // out by WB writes. The stall request is registered and drops on the same
  // edge that commits the head's pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_cnt <= '0;
      stall_o    <= 1'b0;
    end else begin
      if (pop || !not_empty) begin
        starve_cnt <= '0;
      end else if (blocked && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
      stall_o <= (starve_cnt == STARVE_MAX) && head_valid && !pop;
    end
  end

endmodule
